// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the 40 MHz divided-clock monitor.
`timescale 1ns/1ps
package clk_mon_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } clk_mon_state_t;

  localparam int CLK_MON_DIV_DEFAULT  = 16;
  localparam int CLK_MON_LOCK_DEFAULT = 8;
  localparam int CLK_MON_ERRCNT_W     = 8;
endpackage

// File: rtl/clk_div_monitor_if.sv
// Monitor-side signal bundle: divided clock under test, clear, and status outputs.
`timescale 1ns/1ps
interface clk_div_monitor_if #(parameter int DIV = 16);
  import clk_mon_pkg::*;
  localparam int PERIOD_W = $clog2(DIV) + 2;

  logic                        clk40MHz_i;
  logic                        clear_i;
  logic                        locked_o;
  logic                        err_o;
  logic [CLK_MON_ERRCNT_W-1:0] err_cnt_o;
  logic [PERIOD_W-1:0]         period_o;

  modport master (output clk40MHz_i, clear_i, input locked_o, err_o, err_cnt_o, period_o);
  modport slave  (input clk40MHz_i, clear_i, output locked_o, err_o, err_cnt_o, period_o);
endinterface

// File: rtl/clk_mon_edge_det.sv
// Samples the divided clock and flags its edges; `define CLK_MON_SYNC_EN inserts
// a two-flop synchroniser ahead of the sample register.
`timescale 1ns/1ps
module clk_mon_edge_det (
  input  logic ext_clk640MHz_i,
  input  logic rst640MHz_n,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic s_in;
  logic s_q;
  logic s_dly_q;

`ifdef CLK_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge ext_clk640MHz_i or negedge rst640MHz_n) begin
    if (!rst640MHz_n) sync_q <= '0;
    else              sync_q <= {sync_q[0], d_i};
  end
  assign s_in = sync_q[1];
`else
  assign s_in = d_i;
`endif

  always_ff @(posedge ext_clk640MHz_i or negedge rst640MHz_n) begin
    if (!rst640MHz_n) begin
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      s_q     <= s_in;
      s_dly_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q;
  assign fall_o = ~s_q & s_dly_q;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures half-periods of the divided clock, tracks lock and counts errors.
// Build option: CLK_MON_SYNC_EN (synchroniser in clk_mon_edge_det).
`timescale 1ns/1ps
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int DIV        = CLK_MON_DIV_DEFAULT,
  parameter int LOCK_COUNT = CLK_MON_LOCK_DEFAULT
) (
  input  logic             ext_clk640MHz_i,
  input  logic             rst640MHz_n,
  clk_div_monitor_if.slave mon_if
);
  localparam int RUN_W    = $clog2(DIV) + 1;
  localparam int PERIOD_W = $clog2(DIV) + 2;
  localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]  RUN_HALF  = RUN_W'(DIV / 2);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(DIV);
  localparam logic [RUN_W-1:0]  RUN_STUCK = RUN_W'(DIV - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  logic s, rise, fall, trans, stuck, good_half, err;
  clk_mon_state_t              state_q, state_d;
  logic [RUN_W-1:0]            run_q, run_d;
  logic [GOOD_W-1:0]           good_q, good_d;
  logic [RUN_W-1:0]            last_high_q;
  logic [PERIOD_W-1:0]         period_q;
  logic                        locked_q, err_q;
  logic [CLK_MON_ERRCNT_W-1:0] err_cnt_q;

  clk_mon_edge_det u_edge (
    .ext_clk640MHz_i (ext_clk640MHz_i),
    .rst640MHz_n     (rst640MHz_n),
    .d_i             (mon_if.clk40MHz_i),
    .s_o             (s),
    .rise_o          (rise),
    .fall_o          (fall)
  );

  assign trans     = rise | fall;
  // run is about to saturate without an edge; saturation keeps this single-shot
  assign stuck     = !trans && (run_q == RUN_STUCK);
  assign good_half = (run_q == RUN_HALF);

  always_comb begin
    run_d = run_q;
    if (trans)                run_d = RUN_W'(1);
    else if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (trans) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (stuck) begin
          err     = 1'b1;
          state_d = IDLE;
          good_d  = '0;
        end else if (trans) begin
          if (good_half) begin
            good_d = good_q + GOOD_W'(1);
            if (good_q + GOOD_W'(1) == GOOD_LOCK) state_d = LOCKED;
          end else begin
            err    = 1'b1;
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (stuck) begin
          err     = 1'b1;
          state_d = IDLE;
          good_d  = '0;
        end else if (trans && !good_half) begin
          err     = 1'b1;
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ext_clk640MHz_i or negedge rst640MHz_n) begin
    if (!rst640MHz_n) begin
      state_q     <= IDLE;
      run_q       <= '0;
      good_q      <= '0;
      last_high_q <= '0;
      period_q    <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      good_q   <= good_d;
      locked_q <= (state_d == LOCKED);
      err_q    <= err;
      if (trans && !s) last_high_q <= run_q;
      if (rise)        period_q    <= PERIOD_W'(last_high_q) + PERIOD_W'(run_q);
      // clear takes priority over a coincident error
      if (mon_if.clear_i)          err_cnt_q <= '0;
      else if (err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CLK_MON_ERRCNT_W'(1);
    end
  end

  assign mon_if.locked_o  = locked_q;
  assign mon_if.err_o     = err_q;
  assign mon_if.err_cnt_o = err_cnt_q;
  assign mon_if.period_o  = period_q;
endmodule
